ram_burst_master: RTL and testbench

- Initiator-side controller for the single-port `ram` block (clk/we/start/adr/din/dout interface).
- Accepts burst requests (write or read, base address, length) over a valid/ready handshake.
- Streams write data into the RAM and returns read data as a valid-qualified stream.
- Sits between datapath/test logic and `ram`; the only agent driving the RAM's we/start/adr/din.

---
 rtl/ram_master_pkg.sv | 16 +
 rtl/ram_burst_master_if.sv | 38 +++
 rtl/ram_rd_pipe.sv | 49 ++++
 rtl/ram_burst_master.sv | 203 ++++++++++++++++++++
 tb/tb_ram_burst_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_burst_master slice: FSM state encoding and default geometry.
package ram_master_pkg;

    localparam int DW_DEF     = 32;
    localparam int AW_DEF     = 8;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Request / write-stream / read-stream / RAM-side signal bundle for ram_burst_master.
// Modport master is the controller view; modport slave is the client-plus-RAM view.
interface ram_burst_master_if #(
    parameter int DW = 32,
    parameter int AW = 8
) ();

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_adr;
    logic [AW-1:0] req_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          ram_we;
    logic          ram_start;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        input  req_valid, req_write, req_adr, req_len, wr_data, wr_valid, ram_dout,
        output req_ready, wr_ready, rd_data, rd_valid, busy, done,
               ram_we, ram_start, ram_adr, ram_din
    );

    modport slave (
        output req_valid, req_write, req_adr, req_len, wr_data, wr_valid, ram_dout,
        input  req_ready, wr_ready, rd_data, rd_valid, busy, done,
               ram_we, ram_start, ram_adr, ram_din
    );

endinterface

// File: rtl/ram_rd_pipe.sv
// Read-return pipe: RD_LAT-deep tag shift register aligned to the RAM read latency,
// registered data capture and rd_valid generation, plus an empty flag for the drain phase.
module ram_rd_pipe #(
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty
);

    logic [RD_LAT-1:0] tag_r;
    logic [RD_LAT-1:0] tag_next_s;
    logic [DW-1:0]     rd_data_r;
    logic              rd_valid_r;

    // a tag in the top stage means ram_dout carries that beat's data this cycle
    generate
        if (RD_LAT == 1) begin : g_one
            assign tag_next_s = push;
        end else begin : g_many
            assign tag_next_s = {tag_r[RD_LAT-2:0], push};
        end
    endgenerate

    // tag shift, data capture and valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r      <= {RD_LAT{1'b0}};
            rd_data_r  <= {DW{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            tag_r      <= tag_next_s;
            rd_valid_r <= tag_r[RD_LAT-1];
            if (tag_r[RD_LAT-1]) begin
                rd_data_r <= ram_dout;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign empty    = ~|tag_r;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port ram: IDLE/WRITE/READ/DRAIN/DONE sequencer driving we/start/adr/din.
// Optional macro RAM_MASTER_WRAP_CHK_EN adds an err output and rejects bursts that would wrap the address space.
module ram_burst_master
    import ram_master_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef RAM_MASTER_WRAP_CHK_EN
    output logic err,
`endif
    ram_burst_master_if.master bus
);

    localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADR_ZERO = {AW{1'b0}};

    state_t        state_r;
    state_t        state_next_s;
    logic [AW-1:0] cur_adr_r;
    logic [AW-1:0] beats_left_r;
    logic [DW-1:0] din_hold_r;

    logic accept_s;
    logic last_s;
    logic pipe_empty_s;
    logic ovf_s;

    logic req_ready_s;
    logic wr_ready_s;
    logic ram_we_s;
    logic ram_start_s;
    logic push_s;
    logic busy_s;
    logic done_s;

    assign accept_s = bus.req_valid && (state_r == IDLE);
    assign last_s   = (beats_left_r == ADR_ZERO);

`ifdef RAM_MASTER_WRAP_CHK_EN
    logic [AW:0] span_s;
    logic        err_r;

    // carry out of base+len means the burst would cross the top of the address space
    assign span_s = {1'b0, bus.req_adr} + {1'b0, bus.req_len};
    assign ovf_s  = span_s[AW];

    // err is held for exactly the DONE cycle of a rejected request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= ovf_s;
        end else if (state_r == DONE) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign ovf_s = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (ovf_s) begin
                        state_next_s = DONE;
                    end else if (bus.req_write) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (bus.wr_valid && last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = WRITE;
                end
            end
            READ: begin
                if (last_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = READ;
                end
            end
            DRAIN: begin
                if (pipe_empty_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // output decode; RAM strobes depend only on the registered state and the write stream
    always_comb begin
        req_ready_s = 1'b0;
        wr_ready_s  = 1'b0;
        ram_we_s    = 1'b0;
        ram_start_s = 1'b0;
        push_s      = 1'b0;
        busy_s      = 1'b1;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            WRITE: begin
                wr_ready_s = 1'b1;
                if (bus.wr_valid) begin
                    ram_we_s    = 1'b1;
                    ram_start_s = 1'b1;
                end else begin
                    ram_we_s    = 1'b0;
                    ram_start_s = 1'b0;
                end
            end
            READ: begin
                ram_start_s = 1'b1;
                push_s      = 1'b1;
            end
            DRAIN: begin
                ram_start_s = 1'b0;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // burst address / beat counters and the idle value of ram_din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_adr_r    <= ADR_ZERO;
            beats_left_r <= ADR_ZERO;
            din_hold_r   <= {DW{1'b0}};
        end else begin
            if (accept_s) begin
                cur_adr_r    <= bus.req_adr;
                beats_left_r <= bus.req_len;
            end else if (ram_start_s) begin
                cur_adr_r    <= cur_adr_r + ADR_ONE;
                beats_left_r <= beats_left_r - ADR_ONE;
            end
            if (ram_we_s) begin
                din_hold_r <= bus.wr_data;
            end
        end
    end

    ram_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .ram_dout (bus.ram_dout),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .empty    (pipe_empty_s)
    );

    assign bus.req_ready = req_ready_s;
    assign bus.wr_ready  = wr_ready_s;
    assign bus.busy      = busy_s;
    assign bus.done      = done_s;
    assign bus.ram_we    = ram_we_s;
    assign bus.ram_start = ram_start_s;
    assign bus.ram_adr   = cur_adr_r;
    assign bus.ram_din   = ram_we_s ? bus.wr_data : din_hold_r;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: table of bursts against a behavioural RAM,
// scoreboard queues for write beats / read addresses / read data, plus reset-abort and back-to-back sequences.
module tb_ram_burst_master;

    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int RD_LAT = 1;

    typedef struct {
        bit          write;
        logic [7:0]  adr;
        logic [7:0]  len;
        logic [31:0] base;
        bit          gaps;
        int          exp_done;
        int          exp_starts;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_burst_master_if #(.DW(DW), .AW(AW)) bus ();
`ifdef RAM_MASTER_WRAP_CHK_EN
    logic err;
`endif

    ram_burst_master #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef RAM_MASTER_WRAP_CHK_EN
        .err   (err),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural single-port RAM, read latency one cycle
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    always @(posedge clk) begin
        if (bus.ram_start) begin
            if (bus.ram_we) mem[bus.ram_adr] <= bus.ram_din;
            else            bus.ram_dout     <= mem[bus.ram_adr];
        end
    end

    logic [39:0] wq[$];
    logic [7:0]  raq[$];
    logic [31:0] rdq[$];
    int start_cnt, rdv_cnt, done_cnt, first_start, first_rdv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event missing (t=%0t)", name, $time);
    endtask

    // monitor: compares RAM traffic and read returns against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_start) begin
                start_cnt++;
                if (first_start < 0) first_start = cyc;
                if (bus.ram_we) begin
                    if (wq.size() == 0) fail("wr_beat_unexpected");
                    else chk("wr_beat", {bus.ram_adr, bus.ram_din}, wq.pop_front());
                end else begin
                    if (raq.size() == 0) fail("rd_adr_unexpected");
                    else chk("rd_adr", bus.ram_adr, raq.pop_front());
                end
            end
            if (bus.ram_we) chk("we_only_in_write", bus.wr_ready, 1'b1);
            if (bus.rd_valid) begin
                rdv_cnt++;
                if (first_rdv < 0) first_rdv = cyc;
                if (rdq.size() == 0) fail("rd_data_unexpected");
                else chk("rd_data", bus.rd_data, rdq.pop_front());
            end
            if (bus.done) done_cnt++;
        end
    end

    function automatic vec_t mk(bit wr, logic [7:0] adr, logic [7:0] len, logic [31:0] base, bit gaps);
        vec_t v;
        int   n = int'(len) + 1;
        v.write = wr; v.adr = adr; v.len = len; v.base = base; v.gaps = gaps;
`ifdef RAM_MASTER_WRAP_CHK_EN
        v.exp_err = (int'(adr) + int'(len)) > 255;
`else
        v.exp_err = 1'b0;
`endif
        v.exp_starts = v.exp_err ? 0 : n;
        if (v.exp_err)  v.exp_done = 1;
        else if (wr)    v.exp_done = gaps ? 2 * n : n + 1;
        else            v.exp_done = n + RD_LAT + 2;
        return v;
    endfunction

    task automatic clear_counts();
        start_cnt = 0; rdv_cnt = 0; done_cnt = 0; first_start = -1; first_rdv = -1;
    endtask

    task automatic push_reads(input logic [7:0] adr, input logic [7:0] len);
        logic [7:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = adr + i[7:0];
            raq.push_back(a);
            rdq.push_back(shadow[a]);
        end
    endtask

    task automatic issue_req(input bit wr, input logic [7:0] adr, input logic [7:0] len,
                             input bit hold, output int acc);
        int n = 0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_adr = adr; bus.req_len = len;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.req_ready) fail("req_accept_timeout");
        acc = cyc;
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int acc, output int rel);
        rel = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                rel = cyc - acc;
                chk("ready_low_in_done", bus.req_ready, 1'b0);
                break;
            end
            @(posedge clk); #1;
        end
        if (rel < 0) fail("done_timeout");
    endtask

    task automatic run_burst(input vec_t v, output int rel);
        int         acc;
        int         beat = 0;
        bit         von;
        logic [7:0] a;
        if (!v.write && !v.exp_err) push_reads(v.adr, v.len);
        issue_req(v.write, v.adr, v.len, 1'b0, acc);
        rel = -1;
        for (int c = 1; c < 200; c++) begin
            if (v.write && !v.exp_err && beat <= int'(v.len)) begin
                von = v.gaps ? ((c % 2) == 1) : 1'b1;
                bus.wr_valid = von;
                bus.wr_data  = v.base + beat;
                if (von && bus.wr_ready) begin
                    a = v.adr + beat[7:0];
                    wq.push_back({a, v.base + beat});
                    shadow[a] = v.base + beat;
                    beat++;
                end
            end else begin
                bus.wr_valid = 1'b0;
            end
            if (bus.done) begin
                rel = cyc - acc;
                chk("ready_low_in_done", bus.req_ready, 1'b0);
`ifdef RAM_MASTER_WRAP_CHK_EN
                chk("err", err, v.exp_err);
`endif
                break;
            end
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        if (rel < 0) fail("burst_done_timeout");
    endtask

    vec_t vecs[9];

    initial begin
        int         rel, acc, acc2;
        logic [7:0] a;

        vecs[0] = mk(1'b1, 8'h10, 8'd3,  32'hA0, 1'b0);
        vecs[1] = mk(1'b0, 8'h10, 8'd3,  32'h0,  1'b0);
        vecs[2] = mk(1'b1, 8'h40, 8'd1,  32'hB0, 1'b1);
        vecs[3] = mk(1'b0, 8'h40, 8'd1,  32'h0,  1'b0);
        vecs[4] = mk(1'b1, 8'hFE, 8'd3,  32'hC0, 1'b0);
        vecs[5] = mk(1'b0, 8'hFE, 8'd3,  32'h0,  1'b0);
        vecs[6] = mk(1'b0, 8'h00, 8'd0,  32'h0,  1'b0);
        vecs[7] = mk(1'b1, 8'h80, 8'd15, 32'hD0, 1'b0);
        vecs[8] = mk(1'b0, 8'h80, 8'd15, 32'h0,  1'b0);

        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0; shadow[i] = 32'h0;
        end
        bus.ram_dout = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_adr = 8'h0; bus.req_len = 8'h0;
        bus.wr_valid = 1'b0; bus.wr_data = 32'h0;
        clear_counts();
        rst_n = 1'b0;
        #2;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_wr_ready",  bus.wr_ready,  1'b0);
        chk("rst_ram_start", bus.ram_start, 1'b0);
        chk("rst_ram_we",    bus.ram_we,    1'b0);
        chk("rst_ram_adr",   bus.ram_adr,   8'h0);
        chk("rst_ram_din",   bus.ram_din,   32'h0);
        chk("rst_rd_valid",  bus.rd_valid,  1'b0);
        chk("rst_rd_data",   bus.rd_data,   32'h0);
`ifdef RAM_MASTER_WRAP_CHK_EN
        chk("rst_err", err, 1'b0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            clear_counts();
            run_burst(vecs[i], rel);
            chk("done_cycle", rel, vecs[i].exp_done);
            chk("start_count", start_cnt, vecs[i].exp_starts);
            if (vecs[i].write && !vecs[i].exp_err) begin
                for (int k = 0; k <= int'(vecs[i].len); k++) begin
                    a = vecs[i].adr + k[7:0];
                    chk("ram_content", mem[a], vecs[i].base + k);
                end
            end
            if (!vecs[i].write && !vecs[i].exp_err) begin
                chk("rd_latency", first_rdv - first_start, RD_LAT + 1);
                chk("rd_beats", rdv_cnt, int'(vecs[i].len) + 1);
            end
            @(posedge clk); #1;
            chk("done_single_pulse", bus.done, 1'b0);
            chk("idle_ready", bus.req_ready, 1'b1);
            chk("sb_drained", wq.size() + raq.size() + rdq.size(), 0);
        end

        // reset asserted while the third beat of an 8-beat read is on the bus
        clear_counts();
        push_reads(8'h80, 8'd7);
        issue_req(1'b0, 8'h80, 8'd7, 1'b0, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ram_start", bus.ram_start, 1'b0);
        chk("abort_busy",      bus.busy,      1'b0);
        chk("abort_req_ready", bus.req_ready, 1'b1);
        chk("abort_rd_valid",  bus.rd_valid,  1'b0);
        chk("abort_done",      bus.done,      1'b0);
        wq.delete(); raq.delete(); rdq.delete();
        clear_counts();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("abort_no_rd_valid", rdv_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_start", start_cnt, 0);
        run_burst(mk(1'b0, 8'h10, 8'd3, 32'h0, 1'b0), rel);
        chk("post_abort_done_cycle", rel, 4 + RD_LAT + 2);
        chk("post_abort_rd_beats", rdv_cnt, 4);
        @(posedge clk); #1;

        // request held valid across DONE is re-accepted the following cycle
        clear_counts();
        push_reads(8'h10, 8'd3);
        push_reads(8'h10, 8'd3);
        issue_req(1'b0, 8'h10, 8'd3, 1'b1, acc);
        wait_done(acc, rel);
        chk("b2b_first_done", rel, 4 + RD_LAT + 2);
        @(posedge clk); #1;
        chk("b2b_ready_after_done", bus.req_ready, 1'b1);
        acc2 = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b_busy", bus.busy, 1'b1);
        chk("b2b_start", bus.ram_start, 1'b1);
        wait_done(acc2, rel);
        chk("b2b_second_done", rel, 4 + RD_LAT + 2);
        @(posedge clk); #1;
        chk("b2b_starts", start_cnt, 8);
        chk("b2b_rd_beats", rdv_cnt, 8);
        chk("b2b_sb_drained", wq.size() + raq.size() + rdq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
